// File: rtl/gpc_pkg.sv
// Shared definitions for the (2;0;7 -> 4) generalized parallel counter:
// widths, column positions, the full-adder cell and the column reductions.
package gpc_pkg;

    localparam int W0      = 7;
    localparam int W2      = 2;
    localparam int WOUT    = 4;
    localparam int CNT0_W  = 3;

    localparam int COL0_POS = 0;
    localparam int COL2_POS = 2;
    localparam int WGT_COL0 = 1 << COL0_POS;
    localparam int WGT_COL2 = 1 << COL2_POS;

    // Stage-1 state for the two-stage pipeline.
    typedef struct packed {
        logic [CNT0_W-1:0] cnt0;
        logic [W2-1:0]     src2;
    } part_t;

    // Returns {carry, sum}.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Seven weight-1 bits to a 3-bit count using four full adders.
    function automatic logic [CNT0_W-1:0] col0_count(input logic [W0-1:0] b);
        logic [1:0] fa_a;
        logic [1:0] fa_b;
        logic [1:0] fa_c;
        logic [1:0] fa_d;
        fa_a = full_add(b[0], b[1], b[2]);
        fa_b = full_add(b[3], b[4], b[5]);
        fa_c = full_add(fa_a[0], fa_b[0], b[6]);
        // The three weight-2 carries collapse into s1 and the weight-4 s2.
        fa_d = full_add(fa_a[1], fa_b[1], fa_c[1]);
        return {fa_d[1], fa_d[0], fa_c[0]};
    endfunction

    // Column 2: s2 plus both weight-4 inputs; the carry becomes dst[3].
    function automatic logic [WOUT-1:0] col2_sum(input logic [CNT0_W-1:0] cnt0,
                                                 input logic [W2-1:0]     s2);
        logic [1:0]      fa;
        logic [WOUT-1:0] hi;
        fa = full_add(cnt0[2], s2[0], s2[1]);
        hi = WOUT'(fa) << COL2_POS;
        return hi | WOUT'(cnt0[1:0]);
    endfunction

endpackage

// File: rtl/gpc_207_4_if.sv
// Data/valid bundle between a GPC cell and its producer/consumer.
interface gpc_207_4_if;
    import gpc_pkg::*;

    logic            in_valid;
    logic [W0-1:0]   src0;
    logic [W2-1:0]   src2;
    logic [WOUT-1:0] dst;
    logic            out_valid;

    modport master (output in_valid, src0, src2, input dst, out_valid);
    modport slave  (input in_valid, src0, src2, output dst, out_valid);
endinterface

// File: rtl/gpc_207_4_core.sv
// Purely combinational (2;0;7 -> 4) compressor, reusable in other GPC trees.
module gpc207_4_core
    import gpc_pkg::*;
(
    input  logic [W0-1:0]   src0,
    input  logic [W2-1:0]   src2,
    output logic [WOUT-1:0] dst
);

    logic [CNT0_W-1:0] cnt0;

    always_comb begin
        cnt0 = col0_count(src0);
        dst  = col2_sum(cnt0, src2);
    end

endmodule

// File: rtl/gpc_207_4.sv
// Registered (2;0;7 -> 4) GPC cell: LATENCY register stages (1 or 2) with a
// matching valid shift chain; no backpressure.
module gpc_207_4
    import gpc_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    gpc_207_4_if.slave    bus
);

    logic [WOUT-1:0]    dst_q;
    logic [WOUT-1:0]    dst_d;
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;

    assign vld_d[0] = bus.in_valid;
    for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld
        assign vld_d[gi] = vld_q[gi-1];
    end

    if (LATENCY == 1) begin : g_lat1
        logic [WOUT-1:0] sum_w;

        gpc207_4_core u_core (
            .src0 (bus.src0),
            .src2 (bus.src2),
            .dst  (sum_w)
        );

        always_comb begin
            dst_d = sum_w;
        end
    end else begin : g_lat2
        // Column 0 is reduced before the first register; column 2 after it.
        part_t part_q;
        part_t part_d;

        always_comb begin
            part_d.cnt0 = col0_count(bus.src0);
            part_d.src2 = bus.src2;
            dst_d       = col2_sum(part_q.cnt0, part_q.src2);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                part_q <= '0;
            end else begin
                part_q <= part_d;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q <= '0;
            vld_q <= '0;
        end else begin
            dst_q <= dst_d;
            vld_q <= vld_d;
        end
    end

    assign bus.dst       = dst_q;
    assign bus.out_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_gpc_207_4.sv
// Directed and exhaustive checks of gpc_207_4 with LATENCY = 1 and 2 side by side.
module tb_gpc_207_4;
    import gpc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic       pv  = 1'b0;
    logic [3:0] pe  = 4'h0;

    gpc_207_4_if bus1 ();
    gpc_207_4_if bus2 ();

    gpc_207_4 #(.LATENCY(1)) u_lat1 (.clk(clk), .rst(rst), .bus(bus1.slave));
    gpc_207_4 #(.LATENCY(2)) u_lat2 (.clk(clk), .rst(rst), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [6:0] s0, input logic [1:0] s2);
        bus1.in_valid = v; bus1.src0 = s0; bus1.src2 = s2;
        bus2.in_valid = v; bus2.src0 = s0; bus2.src2 = s2;
    endtask

    // One input per cycle; LATENCY=1 shows this vector, LATENCY=2 the previous one.
    task automatic step(input string tag, input logic v, input logic [6:0] s0,
                        input logic [1:0] s2, input logic [3:0] e);
        drive(v, s0, s2);
        @(posedge clk);
        #1;
        check({tag, "_vld_l1"}, {3'b0, bus1.out_valid}, {3'b0, v});
        if (v) check({tag, "_dst_l1"}, bus1.dst, e);
        check({tag, "_vld_l2"}, {3'b0, bus2.out_valid}, {3'b0, pv});
        if (pv) check({tag, "_dst_l2"}, bus2.dst, pe);
        pv = v;
        pe = e;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_dst_l1"}, bus1.dst, 4'h0);
        check({tag, "_vld_l1"}, {3'b0, bus1.out_valid}, 4'h0);
        check({tag, "_dst_l2"}, bus2.dst, 4'h0);
        check({tag, "_vld_l2"}, {3'b0, bus2.out_valid}, 4'h0);
    endtask

    initial begin
        logic [8:0] idx;
        logic [3:0] model;

        drive(1'b0, 7'h00, 2'h0);
        #2;
        check_cleared("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        step("basic", 1'b1, 7'h3d, 2'h2, 4'h9);
        step("flush", 1'b0, 7'h00, 2'h0, 4'h0);

        step("b2b0", 1'b1, 7'h5f, 2'h3, 4'he);
        step("b2b1", 1'b1, 7'h38, 2'h3, 4'hb);
        step("b2b2", 1'b1, 7'h24, 2'h3, 4'ha);
        step("b2b3", 1'b1, 7'h70, 2'h2, 4'h7);

        step("zero", 1'b1, 7'h00, 2'h0, 4'h0);
        step("max",  1'b1, 7'h7f, 2'h3, 4'hf);
        step("c0hi", 1'b1, 7'h5f, 2'h0, 4'h6);
        step("c2hi", 1'b1, 7'h00, 2'h3, 4'h8);

        // Asynchronous reset between edges with results in flight.
        step("pre_rst", 1'b1, 7'h7f, 2'h3, 4'hf);
        drive(1'b1, 7'h7f, 2'h1);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("rst_async");
        @(posedge clk);
        #1;
        check_cleared("rst_hold");
        drive(1'b0, 7'h00, 2'h0);
        rst = 1'b0;
        pv = 1'b0;
        step("post_rst0", 1'b0, 7'h00, 2'h0, 4'h0);
        step("post_rst1", 1'b0, 7'h00, 2'h0, 4'h0);

        step("gap0", 1'b1, 7'h0e, 2'h3, 4'hb);
        step("gap1", 1'b0, 7'h55, 2'h2, 4'h0);
        step("gap2", 1'b1, 7'h2f, 2'h1, 4'h9);
        step("gap3", 1'b0, 7'h00, 2'h0, 4'h0);

        for (int i = 0; i < 512; i++) begin
            idx   = 9'(i);
            model = 4'($countones(idx[6:0]) * WGT_COL0 + $countones(idx[8:7]) * WGT_COL2);
            step("sweep", 1'b1, idx[6:0], idx[8:7], model);
        end
        step("sweep_end", 1'b0, 7'h00, 2'h0, 4'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
